// File: rtl/expr_recognizer_if.sv
`default_nettype none
// ============================================================================
// Module   : expr_recognizer_if
// Brief    : Character stream in, recognizer status out.
// Revision : 1.0 - initial release
// ============================================================================
interface expr_recognizer_if #(
  parameter int MAX_DEPTH = 3,
  parameter int CNT_W     = 8
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic [7:0]         in;
  logic               in_valid;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   opnd_cnt;

  modport master (output in, in_valid, input out, err, depth, opnd_cnt);
  modport slave  (input in, in_valid, output out, err, depth, opnd_cnt);
endinterface
`default_nettype wire

// File: rtl/expr_recognizer.sv
`default_nettype none
// ============================================================================
// Module   : expr_recognizer
// Brief    : Streaming recognizer for ASCII arithmetic expressions with
//            multi-digit operands, + - * /, and bounded parenthesis nesting.
//            Define EXPR_UNARY_MINUS_EN to accept a leading unary '-'.
// Revision : 1.0 - initial release
// ============================================================================
module expr_recognizer #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int CNT_W      = 8
) (
  input  wire logic           clk,
  input  wire logic           clr,
  expr_recognizer_if.slave    bus
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int DCNT_W  = $clog2(MAX_DIGITS + 1);

  localparam logic [7:0] c_PLUS   = 8'h2B;
  localparam logic [7:0] c_MINUS  = 8'h2D;
  localparam logic [7:0] c_STAR   = 8'h2A;
  localparam logic [7:0] c_SLASH  = 8'h2F;
  localparam logic [7:0] c_LPAREN = 8'h28;
  localparam logic [7:0] c_RPAREN = 8'h29;
  localparam logic [7:0] c_ZERO   = 8'h30;
  localparam logic [7:0] c_NINE   = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPND     = 3'd1,
    S_NUM      = 3'd2,
    S_CLOSE    = 3'd3,
`ifdef EXPR_UNARY_MINUS_EN
    S_OPND_NEG = 3'd5,
`endif
    S_ERR      = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DCNT_W-1:0]  r_dcnt,  w_dcnt_nxt;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_out,   w_out_nxt;
  logic               r_err,   w_err_nxt;

  logic w_is_dig, w_is_op, w_is_lp, w_is_rp;

  assign w_is_dig = (bus.in >= c_ZERO) && (bus.in <= c_NINE);
  assign w_is_op  = (bus.in == c_PLUS) || (bus.in == c_MINUS) ||
                    (bus.in == c_STAR) || (bus.in == c_SLASH);
  assign w_is_lp  = (bus.in == c_LPAREN);
  assign w_is_rp  = (bus.in == c_RPAREN);

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_depth_nxt = r_depth;
    w_cnt_nxt   = r_cnt;
    if (bus.in_valid) begin
      case (r_state)
`ifdef EXPR_UNARY_MINUS_EN
        S_IDLE, S_OPND, S_OPND_NEG: begin
`else
        S_IDLE, S_OPND: begin
`endif
          if (w_is_dig) begin
            w_state_nxt = S_NUM;
            w_dcnt_nxt  = DCNT_W'(1);
            if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_is_lp) begin
            if (r_depth == DEPTH_W'(MAX_DEPTH)) begin
              w_state_nxt = S_ERR;
            end else begin
              w_state_nxt = S_OPND;
              w_depth_nxt = r_depth + DEPTH_W'(1);
            end
`ifdef EXPR_UNARY_MINUS_EN
          end else if (bus.in == c_MINUS && r_state != S_OPND_NEG) begin
            w_state_nxt = S_OPND_NEG;
`endif
          end else begin
            w_state_nxt = S_ERR;
          end
        end
        S_NUM, S_CLOSE: begin
          if (w_is_rp) begin
            if (r_depth == '0) begin
              w_state_nxt = S_ERR;
            end else begin
              w_state_nxt = S_CLOSE;
              w_depth_nxt = r_depth - DEPTH_W'(1);
            end
          end else if (w_is_op) begin
            w_state_nxt = S_OPND;
            w_dcnt_nxt  = '0;
          end else if (w_is_dig && r_state == S_NUM) begin
            if (r_dcnt == DCNT_W'(MAX_DIGITS)) w_state_nxt = S_ERR;
            else                               w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
          end else begin
            w_state_nxt = S_ERR;
          end
        end
        // ERR absorbs; unused encodings collapse into it as well.
        default: w_state_nxt = S_ERR;
      endcase
    end
    w_out_nxt = ((w_state_nxt == S_NUM) || (w_state_nxt == S_CLOSE)) && (w_depth_nxt == '0);
    w_err_nxt = (w_state_nxt == S_ERR);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
      r_depth <= '0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_depth <= w_depth_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.out      = r_out;
  assign bus.err      = r_err;
  assign bus.depth    = r_depth;
  assign bus.opnd_cnt = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_expr_recognizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_recognizer
// Brief    : Random and directed stimulus checked against a prefix-scanning
//            model of the expression grammar.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_recognizer;
  localparam int MAX_DIGITS = 4;
  localparam int MAX_DEPTH  = 3;
  localparam int CNT_W      = 8;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic clr = 1'b1;

  expr_recognizer_if #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) bus();

  expr_recognizer #(.MAX_DIGITS(MAX_DIGITS), .MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned hist[$];
  bit e_out, e_err, e_want_opnd;
  int e_depth, e_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rescans the whole accepted history; kinds: 0 start,1 digit,2 op,3 '(',4 ')',5 unary '-'.
  function automatic void run_model();
    int prev = 0, run = 0, d = 0, c = 0;
    bit bad = 0;
    foreach (hist[i]) begin
      byte unsigned ch;
      bit opnd_ok, ok;
      if (bad) break;
      ch = hist[i];
      opnd_ok = (prev == 0 || prev == 2 || prev == 3 || prev == 5);
      ok = 0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
        ok = opnd_ok || (prev == 1 && run < MAX_DIGITS);
        if (ok) begin
          if (prev == 1) run++;
          else begin run = 1; if (c < CMAX) c++; end
          prev = 1;
        end
      end else if (ch == 8'h28) begin
        ok = opnd_ok && d < MAX_DEPTH;
        if (ok) begin d++; prev = 3; end
      end else if (ch == 8'h29) begin
        ok = (prev == 1 || prev == 4) && d > 0;
        if (ok) begin d--; prev = 4; end
      end else if (ch == 8'h2B || ch == 8'h2D || ch == 8'h2A || ch == 8'h2F) begin
        ok = (prev == 1 || prev == 4);
        if (ok) prev = 2;
`ifdef EXPR_UNARY_MINUS_EN
        else if (ch == 8'h2D && (prev == 0 || prev == 2 || prev == 3)) begin
          ok = 1;
          prev = 5;
        end
`endif
      end
      if (!ok) bad = 1;
    end
    e_err       = bad;
    e_out       = !bad && (prev == 1 || prev == 4) && d == 0;
    e_depth     = d;
    e_cnt       = c;
    e_want_opnd = (prev == 0 || prev == 2 || prev == 3 || prev == 5);
  endfunction

  always @(posedge clk) begin
    if (clr) hist.delete();
    else if (bus.in_valid) hist.push_back(bus.in);
    #1;
    run_model();
    chk("out",      int'(bus.out),      int'(e_out));
    chk("err",      int'(bus.err),      int'(e_err));
    chk("depth",    int'(bus.depth),    e_depth);
    chk("opnd_cnt", int'(bus.opnd_cnt), e_cnt);
  end

  task automatic send(input byte unsigned ch);
    @(negedge clk);
    bus.in       = ch;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic clear();
    @(negedge clk);
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  function automatic byte unsigned pick();
    byte unsigned ops[4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    int r = $urandom % 100;
    int r2 = $urandom % 10;
    if (r < 6) return 8'($urandom % 256);
    if (e_want_opnd) begin
      if (r2 < 7) return 8'(8'h30 + $urandom % 10);
      if (r2 < 9) return 8'h28;
      return 8'h2D;
    end
    if (r2 < 6) return ops[$urandom % 4];
    if (r2 < 8) return 8'h29;
    return 8'(8'h30 + $urandom % 10);
  endfunction

  initial begin
    int exp_out[7]   = '{1, 1, 0, 1, 0, 1, 1};
    int exp_depth[7] = '{1, 1, 1, 2, 2, 1, 0};
    string s;
    bus.in       = 8'h00;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("reset_out",   int'(bus.out),      0);
    chk("reset_err",   int'(bus.err),      0);
    chk("reset_depth", int'(bus.depth),    0);
    chk("reset_cnt",   int'(bus.opnd_cnt), 0);

    s = "12+3*45";
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      chk("seq1_out", int'(bus.out), exp_out[i]);
    end
    chk("seq1_cnt", int'(bus.opnd_cnt), 3);
    chk("seq1_err", int'(bus.err), 0);

    clear();
    s = "(1+(2))";
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      chk("paren_depth", int'(bus.depth), exp_depth[i]);
      chk("paren_out",   int'(bus.out),   (i == 6) ? 1 : 0);
    end
    chk("paren_err", int'(bus.err), 0);

    clear();
    send_str("1234");
    chk("digits4_err", int'(bus.err), 0);
    send("5");
    chk("digits5_err", int'(bus.err), 1);
    send_str("+1");
    chk("digits_sticky_err", int'(bus.err), 1);
    chk("digits_sticky_cnt", int'(bus.opnd_cnt), 1);

    clear();
    send_str("(((");
    chk("nest3_err", int'(bus.err), 0);
    send("(");
    chk("nest4_err",   int'(bus.err),   1);
    chk("nest4_depth", int'(bus.depth), 3);
    send("1");
    chk("nest_hold_depth", int'(bus.depth), 3);

    clear();
    send_str("1)");
    chk("underflow_err", int'(bus.err), 1);

    clear();
    send_str("1+");
    for (int i = 0; i < 5; i++) begin
      idle(1);
      @(posedge clk);
      #2;
      chk("idle_out", int'(bus.out), 0);
    end
    send("2");
    chk("resume_out", int'(bus.out), 1);
    chk("resume_cnt", int'(bus.opnd_cnt), 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    clr = 1'b1;
    #1;
    chk("async_out", int'(bus.out),      0);
    chk("async_cnt", int'(bus.opnd_cnt), 0);
    chk("async_err", int'(bus.err),      0);
    @(negedge clk);
    clr = 1'b0;

`ifdef EXPR_UNARY_MINUS_EN
    send("-");
    chk("neg_sign_out", int'(bus.out), 0);
    chk("neg_sign_err", int'(bus.err), 0);
    send("7");
    chk("neg_out", int'(bus.out), 1);
    clear();
    send_str("--");
    chk("dbl_neg_err", int'(bus.err), 1);
    send("7");
    chk("dbl_neg_err2", int'(bus.err), 1);
`else
    send("-");
    chk("minus_err", int'(bus.err), 1);
`endif
    clear();

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ((e_err && ($urandom % 4 == 0)) || ($urandom % 80 == 0) || hist.size() > 40) begin
        clr          = 1'b1;
        bus.in_valid = 1'b0;
      end else begin
        clr          = 1'b0;
        bus.in_valid = ($urandom % 5) != 0;
        bus.in       = pick();
      end
    end
    @(negedge clk);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
